read_dispatch: RTL and testbench
================================

# read_dispatch

Upstream feeder for the read-to-MEM seeding engine. Accepts reads as an AXI4-Stream of packed nucleotide symbols, unpacks each into a `READ_LEN`-entry `Symbol` array and holds it in one of two ping-pong slots. Issues one `start` per read to the seeding engine and holds that read's array and id stable until the engine reports `finish`, so loading of read n+1 overlaps seeding of read n.

## Interface
- `READ_LEN`, 76, symbols per read; must match the seeding engine.
- `SYM_PER_BEAT`, 8, symbols per 32-bit beat (4-bit nibble each, bits [4k+3:4k] = symbol k).
- `BODY_BEATS`, ceil(READ_LEN/SYM_PER_BEAT) = 10, derived localparam.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `s_axis_read_tdata`  in  32  header beat: [RID_W-1:0] = read id; body beats: packed symbols.
- `s_axis_read_tvalid`  in  1  beat valid.
- `s_axis_read_tready`  out  1  beat accepted when tvalid&tready.
- `s_axis_read_tlast`  in  1  marks final body beat of a read.
- `read_out[0:READ_LEN-1]`  out  Symbol  read array to seeding engine.
- `read_id_out`  out  RID_W  id of read on `read_out`.
- `start`  out  1  one-cycle pulse, read valid on `read_out`.
- `seed_finish`  in  1  one-cycle pulse from engine, current read done.
- `seed_busy`  in  1  engine busy.
- `reads_done`  out  32  count of `seed_finish` pulses, wraps.
- `err_cnt`  out  16  count of malformed reads, saturates at 0xFFFF.
- `idle`  out  1  both slots empty and dispatcher idle.

## Operation
- Two slots, each EMPTY / FULL / ACTIVE. Load pointer `wr_sel`, dispatch pointer `rd_sel`, both toggle; reads dispatched strictly in arrival order.
- Load FSM: L_HDR → L_BODY → L_HDR; L_DROP on error.
  - L_HDR: tready = (slot[wr_sel]==EMPTY). On handshake latch id, beat index = 0, go L_BODY. If tlast on header beat: err_cnt++, stay L_HDR, nothing written.
  - L_BODY: tready=1. Beat b writes symbols b*8..b*8+7; indices ≥ READ_LEN ignored (last beat uses 4 of 8). Nibble > 4 written as `sym_N`.
  - On beat BODY_BEATS-1 with tlast: slot FULL, toggle `wr_sel`, go L_HDR.
  - tlast earlier than beat BODY_BEATS-1: err_cnt++, slot stays EMPTY, go L_HDR.
  - beat BODY_BEATS-1 without tlast: err_cnt++, slot stays EMPTY, go L_DROP.
  - L_DROP: tready=1, discard beats up to and including tlast, then L_HDR.
- Dispatch FSM: D_IDLE, D_RUN.
  - D_IDLE: if slot[rd_sel]==FULL and !seed_busy: register `start`=1, slot ACTIVE, go D_RUN.
  - D_RUN: on `seed_finish`: slot EMPTY, toggle `rd_sel`, reads_done++, go D_IDLE. `seed_finish` in D_IDLE ignored (not counted).
- `read_out`/`read_id_out` mux from slot[rd_sel]; the ACTIVE slot is never written, so outputs stable from `start` until `seed_finish`.

## Timing
- Reset: tready=0, start=0, reads_done=0, err_cnt=0, idle=1, slots EMPTY, pointers 0, FSMs L_HDR/D_IDLE; slot contents reset to `sym_N`, ids 0.
- Reset mid-read or mid-seeding: partial read and in-flight read discarded; engine shares `rst`.
- Last body beat handshake in cycle t → slot FULL at t+1 → `start` high in cycle t+2 (if engine free), exactly one cycle.
- Back-to-back: `seed_finish` in cycle f, next slot FULL → `start` in f+2 (D_IDLE in f+1).
- Both slots FULL/ACTIVE: tready=0 in L_HDR until a slot frees; body beats never stall (slot reserved at header).
- `seed_finish` and slot fill in same cycle: both take effect; no interaction (different slots).
- Minimum read interval on stream: 11 beats.

## Structure
- `BwaMemDefines` package: reuse `Symbol`, `sym_N`, `RID_W`; add `RD_SYM_PER_BEAT` and typedef `SlotState` {EMPTY, FULL, ACTIVE}.
- Sub-module `read_slot_buf`: one slot's array, id and state register with write-beat and clear ports; instantiated twice.

## Test plan
- One read, id 0x15, symbols k%4, 11 beats, no stall → start 2 cycles after tlast beat, read_out[k]=k%4, read_id_out=0x15, reads_done=1 after finish.
- Three reads back-to-back, engine takes 500 cycles each → read 3 header stalls (tready=0) until first finish; dispatch order ids 1,2,3.
- Body nibble 0xF at symbol 10 → read_out[10]=sym_N.
- tlast on body beat 5 → err_cnt=1, no start, next well-formed read dispatched normally.
- Missing tlast on beat 9, three extra beats with tlast on last → err_cnt=1, extras dropped, next read ok.
- rst asserted mid-body and during D_RUN → all outputs at reset values next cycle, idle=1.

Source files
------------

// File: rtl/read_dispatch_pkg.sv
// Shared types for the read dispatcher: nucleotide symbols, slot states and FSM encodings.
package read_dispatch_pkg;

  localparam int RID_W           = 16;
  localparam int RD_READ_LEN     = 76;
  localparam int RD_SYM_PER_BEAT = 8;

  typedef enum logic [2:0] {
    sym_A = 3'd0,
    sym_C = 3'd1,
    sym_G = 3'd2,
    sym_T = 3'd3,
    sym_N = 3'd4
  } Symbol;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    ACTIVE = 2'd2
  } SlotState;

  typedef enum logic [1:0] {
    L_HDR  = 2'd0,
    L_BODY = 2'd1,
    L_DROP = 2'd2
  } load_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_RUN  = 1'b1
  } disp_state_t;

  // Any nibble outside the A/C/G/T/N codes is an unknown base.
  function automatic Symbol nib_to_sym(input logic [3:0] nib);
    Symbol s;
    case (nib)
      4'd0:    s = sym_A;
      4'd1:    s = sym_C;
      4'd2:    s = sym_G;
      4'd3:    s = sym_T;
      4'd4:    s = sym_N;
      default: s = sym_N;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/read_dispatch_slot_buf.sv
// One ping-pong slot: unpacked symbol array, read id and EMPTY/FULL/ACTIVE state.
module read_slot_buf
  import read_dispatch_pkg::*;
#(
  parameter int READ_LEN     = RD_READ_LEN,
  parameter int SYM_PER_BEAT = RD_SYM_PER_BEAT,
  parameter int BEAT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_id_we,
  input  logic [RID_W-1:0]  i_id,
  input  logic              i_beat_we,
  input  logic [BEAT_W-1:0] i_beat_idx,
  input  logic [31:0]       i_beat_data,
  input  logic              i_set_full,
  input  logic              i_set_active,
  input  logic              i_clear,
  output Symbol             o_syms [0:READ_LEN-1],
  output logic [RID_W-1:0]  o_id,
  output SlotState          o_state
);

  Symbol            r_syms [0:READ_LEN-1];
  logic [RID_W-1:0] r_id;
  SlotState         r_state;

  // Symbol k lives in beat k/SYM_PER_BEAT; indices past the read end are never addressed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < READ_LEN; k++) begin
      if (rst) begin
        r_syms[k] <= sym_N;
      end else if (i_beat_we && (i_beat_idx == BEAT_W'(k / SYM_PER_BEAT))) begin
        r_syms[k] <= nib_to_sym(i_beat_data[4*(k % SYM_PER_BEAT) +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= '0;
      r_state <= EMPTY;
    end else begin
      if (i_id_we) r_id <= i_id;
      if (i_clear)           r_state <= EMPTY;
      else if (i_set_full)   r_state <= FULL;
      else if (i_set_active) r_state <= ACTIVE;
    end
  end

  assign o_syms  = r_syms;
  assign o_id    = r_id;
  assign o_state = r_state;

endmodule

// File: rtl/read_dispatch.sv
// Unpacks streamed reads into two ping-pong slots and hands them, in arrival order,
// to the seeding engine; a slot is held stable from start until seed_finish.
module read_dispatch
  import read_dispatch_pkg::*;
#(
  parameter int READ_LEN     = RD_READ_LEN,
  parameter int SYM_PER_BEAT = RD_SYM_PER_BEAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s_axis_read_tdata,
  input  logic             s_axis_read_tvalid,
  output logic             s_axis_read_tready,
  input  logic             s_axis_read_tlast,
  output Symbol            read_out [0:READ_LEN-1],
  output logic [RID_W-1:0] read_id_out,
  output logic             start,
  input  logic             seed_finish,
  input  logic             seed_busy,
  output logic [31:0]      reads_done,
  output logic [15:0]      err_cnt,
  output logic             idle
);

  localparam int BODY_BEATS = (READ_LEN + SYM_PER_BEAT - 1) / SYM_PER_BEAT;
  localparam int BEAT_W     = (BODY_BEATS > 1) ? $clog2(BODY_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BODY_BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  load_state_t       r_load, w_load_nxt;
  disp_state_t       r_disp, w_disp_nxt;
  logic              r_wr_sel, r_rd_sel, r_live, r_start;
  logic [BEAT_W-1:0] r_beat_idx;
  logic [31:0]       r_reads_done;
  logic [15:0]       r_err_cnt;

  Symbol            w_syms0 [0:READ_LEN-1];
  Symbol            w_syms1 [0:READ_LEN-1];
  logic [RID_W-1:0] w_id0, w_id1;
  SlotState         w_state0, w_state1, w_wr_state, w_rd_state;
  logic w_tready, w_id_we, w_beat_we, w_fill, w_err;
  logic w_set_active, w_clear, w_start_nxt;

  assign w_wr_state = r_wr_sel ? w_state1 : w_state0;
  assign w_rd_state = r_rd_sel ? w_state1 : w_state0;

  // Load FSM: the header reserves an empty slot, so body beats never stall.
  always_comb begin
    w_load_nxt = r_load;
    w_tready   = 1'b0;
    w_id_we    = 1'b0;
    w_beat_we  = 1'b0;
    w_fill     = 1'b0;
    w_err      = 1'b0;
    case (r_load)
      L_HDR: begin
        w_tready = r_live && (w_wr_state == EMPTY);
        if (w_tready && s_axis_read_tvalid) begin
          if (s_axis_read_tlast) begin
            w_err = 1'b1;
          end else begin
            w_id_we    = 1'b1;
            w_load_nxt = L_BODY;
          end
        end else begin
          w_load_nxt = L_HDR;
        end
      end
      L_BODY: begin
        w_tready = r_live;
        if (w_tready && s_axis_read_tvalid) begin
          w_beat_we = 1'b1;
          if (r_beat_idx == LAST_BEAT) begin
            if (s_axis_read_tlast) begin
              w_fill     = 1'b1;
              w_load_nxt = L_HDR;
            end else begin
              w_err      = 1'b1;
              w_load_nxt = L_DROP;
            end
          end else if (s_axis_read_tlast) begin
            w_err      = 1'b1;
            w_load_nxt = L_HDR;
          end else begin
            w_load_nxt = L_BODY;
          end
        end else begin
          w_load_nxt = L_BODY;
        end
      end
      L_DROP: begin
        w_tready = r_live;
        if (w_tready && s_axis_read_tvalid && s_axis_read_tlast) begin
          w_load_nxt = L_HDR;
        end else begin
          w_load_nxt = L_DROP;
        end
      end
      default: w_load_nxt = L_HDR;
    endcase
  end

  // Dispatch FSM: a finish seen while idle belongs to no read and is ignored.
  always_comb begin
    w_disp_nxt   = r_disp;
    w_set_active = 1'b0;
    w_clear      = 1'b0;
    w_start_nxt  = 1'b0;
    case (r_disp)
      D_IDLE: begin
        if ((w_rd_state == FULL) && !seed_busy) begin
          w_start_nxt  = 1'b1;
          w_set_active = 1'b1;
          w_disp_nxt   = D_RUN;
        end else begin
          w_disp_nxt = D_IDLE;
        end
      end
      D_RUN: begin
        if (seed_finish) begin
          w_clear    = 1'b1;
          w_disp_nxt = D_IDLE;
        end else begin
          w_disp_nxt = D_RUN;
        end
      end
      default: w_disp_nxt = D_IDLE;
    endcase
  end

  // r_live keeps tready low while rst is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load       <= L_HDR;
      r_disp       <= D_IDLE;
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_live       <= 1'b0;
      r_start      <= 1'b0;
      r_beat_idx   <= '0;
      r_reads_done <= 32'd0;
      r_err_cnt    <= 16'd0;
    end else begin
      r_live  <= 1'b1;
      r_load  <= w_load_nxt;
      r_disp  <= w_disp_nxt;
      r_start <= w_start_nxt;
      if (w_id_we)        r_beat_idx <= '0;
      else if (w_beat_we) r_beat_idx <= r_beat_idx + BEAT_ONE;
      if (w_fill) r_wr_sel <= ~r_wr_sel;
      if (w_clear) begin
        r_rd_sel     <= ~r_rd_sel;
        r_reads_done <= r_reads_done + 32'd1;
      end
      if (w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  read_slot_buf #(.READ_LEN(READ_LEN), .SYM_PER_BEAT(SYM_PER_BEAT), .BEAT_W(BEAT_W)) u_slot0 (
    .clk(clk), .rst(rst),
    .i_id_we(w_id_we && !r_wr_sel), .i_id(s_axis_read_tdata[RID_W-1:0]),
    .i_beat_we(w_beat_we && !r_wr_sel), .i_beat_idx(r_beat_idx), .i_beat_data(s_axis_read_tdata),
    .i_set_full(w_fill && !r_wr_sel), .i_set_active(w_set_active && !r_rd_sel),
    .i_clear(w_clear && !r_rd_sel),
    .o_syms(w_syms0), .o_id(w_id0), .o_state(w_state0)
  );

  read_slot_buf #(.READ_LEN(READ_LEN), .SYM_PER_BEAT(SYM_PER_BEAT), .BEAT_W(BEAT_W)) u_slot1 (
    .clk(clk), .rst(rst),
    .i_id_we(w_id_we && r_wr_sel), .i_id(s_axis_read_tdata[RID_W-1:0]),
    .i_beat_we(w_beat_we && r_wr_sel), .i_beat_idx(r_beat_idx), .i_beat_data(s_axis_read_tdata),
    .i_set_full(w_fill && r_wr_sel), .i_set_active(w_set_active && r_rd_sel),
    .i_clear(w_clear && r_rd_sel),
    .o_syms(w_syms1), .o_id(w_id1), .o_state(w_state1)
  );

  always_comb begin
    for (int k = 0; k < READ_LEN; k++) begin
      read_out[k] = r_rd_sel ? w_syms1[k] : w_syms0[k];
    end
  end

  assign read_id_out        = r_rd_sel ? w_id1 : w_id0;
  assign s_axis_read_tready = w_tready;
  assign start              = r_start;
  assign reads_done         = r_reads_done;
  assign err_cnt            = r_err_cnt;
  assign idle               = (w_state0 == EMPTY) && (w_state1 == EMPTY) && (r_disp == D_IDLE);

endmodule

// File: tb/tb_read_dispatch.sv
// Self-checking bench for read_dispatch: randomized reads, a behavioural seeding-engine
// model and an in-order expected-read queue.
module tb_read_dispatch;
  import read_dispatch_pkg::*;

  localparam int RL = 76;
  localparam int BODY_BEATS = (RL + 7) / 8;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] tdata;
  logic tvalid, tready, tlast;
  Symbol read_out [0:RL-1];
  logic [RID_W-1:0] read_id_out;
  logic start, seed_finish, seed_busy;
  logic [31:0] reads_done;
  logic [15:0] err_cnt;
  logic idle;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, hs_cyc = 0, n_start_hi = 0;
  int eng_lat = 10, stray_req = 0, stray_done = 0;
  int exp_err = 0, fin_base = 0;
  logic [3:0] g_nib [0:RL-1];
  logic [RID_W-1:0] cap_id_q [$];
  logic [3*RL-1:0] cap_sym_q [$];
  int cap_cyc_q [$];
  int fin_cyc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (start === 1'b1) n_start_hi <= n_start_hi + 1;

  read_dispatch dut (
    .clk(clk), .rst(rst),
    .s_axis_read_tdata(tdata), .s_axis_read_tvalid(tvalid),
    .s_axis_read_tready(tready), .s_axis_read_tlast(tlast),
    .read_out(read_out), .read_id_out(read_id_out), .start(start),
    .seed_finish(seed_finish), .seed_busy(seed_busy),
    .reads_done(reads_done), .err_cnt(err_cnt), .idle(idle)
  );

  // Seeding-engine model: snapshots each dispatched read, stays busy eng_lat cycles, then finishes.
  initial begin : engine
    logic [3*RL-1:0] v;
    seed_finish = 1'b0;
    seed_busy   = 1'b0;
    forever begin
      @(negedge clk);
      if (start === 1'b1 && rst === 1'b0) begin
        for (int k = 0; k < RL; k++) v[3*k +: 3] = read_out[k];
        cap_sym_q.push_back(v);
        cap_id_q.push_back(read_id_out);
        cap_cyc_q.push_back(cyc);
        seed_busy = 1'b1;
        for (int i = 0; i < eng_lat && !rst; i++) @(negedge clk);
        if (!rst) begin
          seed_finish = 1'b1;
          fin_cyc_q.push_back(cyc);
          @(negedge clk);
          seed_finish = 1'b0;
        end
        seed_busy = 1'b0;
      end else if (stray_done < stray_req && rst === 1'b0) begin
        seed_finish = 1'b1;
        @(negedge clk);
        seed_finish = 1'b0;
        stray_done++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Spec rule: nibble 0..4 is the symbol code, anything larger becomes sym_N.
  function automatic logic [3*RL-1:0] exp_pack();
    logic [3*RL-1:0] r;
    for (int k = 0; k < RL; k++) r[3*k +: 3] = (g_nib[k] > 4'd4) ? 3'd4 : g_nib[k][2:0];
    return r;
  endfunction

  function automatic logic [3*RL-1:0] cur_pack();
    logic [3*RL-1:0] r;
    for (int k = 0; k < RL; k++) r[3*k +: 3] = read_out[k];
    return r;
  endfunction

  task automatic rand_nibs(input int maxv);
    for (int k = 0; k < RL; k++) g_nib[k] = 4'($urandom_range(0, maxv));
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic l, output bit ok);
    int n;
    tdata = d; tlast = l; tvalid = 1'b1; n = 0;
    while (tready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    ok = (tready === 1'b1);
    hs_cyc = cyc;
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  // mode 0: well formed; 1: tlast on body beat bad_beat; 2: no tlast on last beat, 3 extras.
  task automatic send_read(input logic [RID_W-1:0] id, input int mode, input int bad_beat,
                           output bit ok, output int hdr_c, output int last_c);
    logic [31:0] d;
    bit o;
    int nb;
    d = $urandom; d[RID_W-1:0] = id;
    drive_beat(d, 1'b0, o); ok = o; hdr_c = hs_cyc;
    nb = (mode == 1) ? bad_beat + 1 : ((mode == 2) ? BODY_BEATS + 3 : BODY_BEATS);
    for (int b = 0; b < nb; b++) begin
      d = $urandom;
      for (int j = 0; j < 8; j++) if (b*8 + j < RL) d[4*j +: 4] = g_nib[b*8 + j];
      drive_beat(d, (b == nb - 1), o); ok &= o;
    end
    last_c = hs_cyc;
  endtask

  task automatic wait_caps(input int target, input int budget, output bit ok);
    int n = 0;
    while (cap_id_q.size() < target && n < budget) begin @(negedge clk); n++; end
    ok = (cap_id_q.size() >= target);
  endtask

  task automatic wait_fins(input int target, input int budget, output bit ok);
    int n = 0;
    while (fin_cyc_q.size() < target && n < budget) begin @(negedge clk); n++; end
    ok = (fin_cyc_q.size() >= target);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    bit allN = 1'b1;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = 32'd0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < RL; k++) if (read_out[k] !== sym_N) allN = 1'b0;
    n_tests++; if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", tready); end
    n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
    n_tests++; if (reads_done !== 32'd0) begin n_fail++; $display("FAIL reset_done: got %0d want 0", reads_done); end
    n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_tests++; if (read_id_out !== '0) begin n_fail++; $display("FAIL reset_id: got %0h want 0", read_id_out); end
    n_tests++; if (!allN) begin n_fail++; $display("FAIL reset_syms: got non-N symbol want all sym_N"); end
    rst = 1'b0;
    fin_base = fin_cyc_q.size();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok, ok2; int h, t, cb, fb, s0; logic [3*RL-1:0] e;
    eng_lat = 20;
    for (int k = 0; k < RL; k++) g_nib[k] = 4'(k % 4);
    e = exp_pack(); cb = cap_id_q.size(); fb = fin_cyc_q.size(); s0 = n_start_hi;
    send_read(16'h0015, 0, 0, ok, h, t);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_accept: got stall timeout want accepted"); end
    wait_caps(cb + 1, 50, ok2);
    n_tests++;
    if (!ok2) begin n_fail++; $display("FAIL single_start: got no start want start"); end
    else begin
      n_tests++; if (cap_cyc_q[cb] !== t + 2) begin n_fail++; $display("FAIL single_latency: got cycle %0d want %0d", cap_cyc_q[cb], t + 2); end
      n_tests++; if (cap_id_q[cb] !== 16'h0015) begin n_fail++; $display("FAIL single_id: got %0h want 15", cap_id_q[cb]); end
      n_tests++; if (cap_sym_q[cb] !== e) begin n_fail++; $display("FAIL single_syms: got %h want %h", cap_sym_q[cb], e); end
      repeat (8) @(negedge clk);
      n_tests++; if (cur_pack() !== e || read_id_out !== 16'h0015) begin n_fail++; $display("FAIL single_stable: got id %0h want 15 with unchanged symbols", read_id_out); end
      n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", idle); end
    end
    wait_fins(fb + 1, 100, ok);
    n_tests++; if (reads_done !== 32'(fin_cyc_q.size() - fin_base)) begin n_fail++; $display("FAIL single_done: got %0d want %0d", reads_done, fin_cyc_q.size() - fin_base); end
    n_tests++; if (n_start_hi - s0 !== 1) begin n_fail++; $display("FAIL single_pulse: got %0d start cycles want 1", n_start_hi - s0); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_back_to_back();
    bit ok; int h [3]; int t [3]; int cb, fb; logic [3*RL-1:0] e [3];
    eng_lat = 500; cb = cap_id_q.size(); fb = fin_cyc_q.size();
    for (int i = 0; i < 3; i++) begin
      rand_nibs(4); e[i] = exp_pack();
      send_read(16'(i + 1), 0, 0, ok, h[i], t[i]);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_accept%0d: got stall timeout want accepted", i); end
    end
    wait_fins(fb + 3, 3000, ok);
    n_tests++;
    if (!ok || cap_id_q.size() < cb + 3) begin n_fail++; $display("FAIL b2b_finish: got %0d finishes want 3", fin_cyc_q.size() - fb); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (cap_id_q[cb+i] !== 16'(i + 1)) begin n_fail++; $display("FAIL b2b_order%0d: got id %0h want %0h", i, cap_id_q[cb+i], i + 1); end
        n_tests++; if (cap_sym_q[cb+i] !== e[i]) begin n_fail++; $display("FAIL b2b_syms%0d: got %h want %h", i, cap_sym_q[cb+i], e[i]); end
      end
      n_tests++; if (cap_cyc_q[cb] !== t[0] + 2) begin n_fail++; $display("FAIL b2b_first: got cycle %0d want %0d", cap_cyc_q[cb], t[0] + 2); end
      n_tests++; if (cap_cyc_q[cb+1] !== fin_cyc_q[fb] + 2) begin n_fail++; $display("FAIL b2b_next: got cycle %0d want %0d", cap_cyc_q[cb+1], fin_cyc_q[fb] + 2); end
      n_tests++; if (h[2] !== fin_cyc_q[fb] + 1) begin n_fail++; $display("FAIL b2b_stall: got header cycle %0d want %0d", h[2], fin_cyc_q[fb] + 1); end
    end
    n_tests++; if (reads_done !== 32'(fin_cyc_q.size() - fin_base)) begin n_fail++; $display("FAIL b2b_done: got %0d want %0d", reads_done, fin_cyc_q.size() - fin_base); end
  endtask

  task automatic test_bad_nibble();
    bit ok; int h, t, cb, fb; logic [3*RL-1:0] e;
    eng_lat = 5; cb = cap_id_q.size(); fb = fin_cyc_q.size();
    rand_nibs(4); g_nib[10] = 4'hF; g_nib[RL-1] = 4'h9; e = exp_pack();
    send_read(16'h0BAD, 0, 0, ok, h, t);
    wait_fins(fb + 1, 200, ok);
    n_tests++;
    if (!ok || cap_id_q.size() <= cb) begin n_fail++; $display("FAIL nib_dispatch: got no dispatch want dispatch"); end
    else begin
      n_tests++; if (cap_sym_q[cb][30 +: 3] !== 3'd4) begin n_fail++; $display("FAIL nib_sym10: got %0d want 4", cap_sym_q[cb][30 +: 3]); end
      n_tests++; if (cap_sym_q[cb] !== e) begin n_fail++; $display("FAIL nib_syms: got %h want %h", cap_sym_q[cb], e); end
    end
  endtask

  // mode -1 is a header beat carrying tlast; 1 and 2 are the body error cases.
  task automatic test_malformed(input int mode, input int bad_beat);
    bit ok; int h, t, cb, fb; logic [3*RL-1:0] e; logic [31:0] d;
    eng_lat = 5; cb = cap_id_q.size(); fb = fin_cyc_q.size();
    rand_nibs(4);
    if (mode < 0) begin d = $urandom; drive_beat(d, 1'b1, ok); end
    else send_read(16'h0EEE, mode, bad_beat, ok, h, t);
    exp_err++;
    repeat (30) @(negedge clk);
    n_tests++; if (cap_id_q.size() !== cb) begin n_fail++; $display("FAIL bad%0d_nostart: got %0d starts want 0", mode, cap_id_q.size() - cb); end
    n_tests++; if (err_cnt !== 16'(exp_err)) begin n_fail++; $display("FAIL bad%0d_err: got %0d want %0d", mode, err_cnt, exp_err); end
    rand_nibs(15); e = exp_pack();
    send_read(16'h002A, 0, 0, ok, h, t);
    wait_fins(fb + 1, 200, ok);
    n_tests++;
    if (!ok || cap_id_q.size() <= cb) begin n_fail++; $display("FAIL bad%0d_recover: got no dispatch want dispatch", mode); end
    else begin
      n_tests++; if (cap_id_q[cb] !== 16'h002A || cap_sym_q[cb] !== e) begin n_fail++; $display("FAIL bad%0d_next: got id %0h want 2a with matching symbols", mode, cap_id_q[cb]); end
      n_tests++; if (cap_cyc_q[cb] !== t + 2) begin n_fail++; $display("FAIL bad%0d_latency: got cycle %0d want %0d", mode, cap_cyc_q[cb], t + 2); end
    end
  endtask

  task automatic test_stray_finish();
    int s0, n; logic [31:0] d0;
    s0 = n_start_hi; d0 = reads_done; n = 0;
    stray_req++;
    while (stray_done < stray_req && n < 50) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    n_tests++; if (reads_done !== d0) begin n_fail++; $display("FAIL stray_done: got %0d want %0d", reads_done, d0); end
    n_tests++; if (n_start_hi !== s0 || idle !== 1'b1) begin n_fail++; $display("FAIL stray_state: got %0d starts idle %b want 0 starts idle 1", n_start_hi - s0, idle); end
  endtask

  task automatic test_random();
    bit ok; int h, t, cb, fb, mode;
    logic [RID_W-1:0] exp_id_q [$]; logic [3*RL-1:0] exp_sym_q [$]; logic [RID_W-1:0] id;
    cb = cap_id_q.size(); fb = fin_cyc_q.size();
    for (int r = 0; r < 10; r++) begin
      eng_lat = $urandom_range(1, 40);
      mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      rand_nibs(15); id = 16'($urandom);
      if (mode == 0) begin exp_id_q.push_back(id); exp_sym_q.push_back(exp_pack()); end
      else exp_err++;
      send_read(id, mode, $urandom_range(0, BODY_BEATS - 2), ok, h, t);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_fins(fb + exp_id_q.size(), 2000, ok);
    n_tests++;
    if (cap_id_q.size() !== cb + exp_id_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d reads want %0d", cap_id_q.size() - cb, exp_id_q.size()); end
    else begin
      for (int i = 0; i < exp_id_q.size(); i++) begin
        n_tests++; if (cap_id_q[cb+i] !== exp_id_q[i] || cap_sym_q[cb+i] !== exp_sym_q[i]) begin n_fail++; $display("FAIL rand_read%0d: got id %0h want %0h with matching symbols", i, cap_id_q[cb+i], exp_id_q[i]); end
      end
    end
    n_tests++; if (err_cnt !== 16'(exp_err)) begin n_fail++; $display("FAIL rand_err: got %0d want %0d", err_cnt, exp_err); end
    n_tests++; if (reads_done !== 32'(fin_cyc_q.size() - fin_base)) begin n_fail++; $display("FAIL rand_done: got %0d want %0d", reads_done, fin_cyc_q.size() - fin_base); end
  endtask

  task automatic test_reset_mid();
    bit ok, allN = 1'b1; int h, t, cb, fb; logic [31:0] d; logic [3*RL-1:0] e;
    eng_lat = 1000; cb = cap_id_q.size();
    rand_nibs(4);
    send_read(16'h00A1, 0, 0, ok, h, t);
    wait_caps(cb + 1, 50, ok);
    d = $urandom; d[RID_W-1:0] = 16'h00B2;
    drive_beat(d, 1'b0, ok);
    for (int b = 0; b < 4; b++) begin d = $urandom; drive_beat(d, 1'b0, ok); end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < RL; k++) if (read_out[k] !== sym_N) allN = 1'b0;
    n_tests++; if (tready !== 1'b0 || start !== 1'b0) begin n_fail++; $display("FAIL rstmid_hs: got tready %b start %b want 0 0", tready, start); end
    n_tests++; if (reads_done !== 32'd0 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d %0d want 0 0", reads_done, err_cnt); end
    n_tests++; if (idle !== 1'b1 || read_id_out !== '0 || !allN) begin n_fail++; $display("FAIL rstmid_state: got idle %b id %0h want idle 1 id 0 all sym_N", idle, read_id_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0; exp_err = 0; fin_base = fin_cyc_q.size();
    repeat (3) @(negedge clk);
    eng_lat = 5; cb = cap_id_q.size(); fb = fin_cyc_q.size();
    rand_nibs(4); e = exp_pack();
    send_read(16'h00C3, 0, 0, ok, h, t);
    wait_fins(fb + 1, 200, ok);
    n_tests++;
    if (!ok || cap_id_q.size() !== cb + 1) begin n_fail++; $display("FAIL rstmid_after: got %0d reads want 1", cap_id_q.size() - cb); end
    else begin
      n_tests++; if (cap_id_q[cb] !== 16'h00C3 || cap_sym_q[cb] !== e) begin n_fail++; $display("FAIL rstmid_read: got id %0h want c3 with matching symbols", cap_id_q[cb]); end
    end
    n_tests++; if (reads_done !== 32'd1) begin n_fail++; $display("FAIL rstmid_done: got %0d want 1", reads_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_nibble();
    test_malformed(-1, 0);
    test_malformed(1, 5);
    test_malformed(2, 0);
    test_stray_finish();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
